// File: rtl/tlul_socket_1n.sv
// tlul_socket_1n: 1-to-N TL-UL socket with address decode and in-order outstanding tracking.
// Define TLUL_SOCKET_ERR_RESP_EN to answer unmapped requests internally; otherwise they go to slave NUM_SLAVES-1.
module tlul_socket_1n #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int SIZE_WIDTH = 3,
  parameter int SRC_WIDTH = 2,
  parameter int SINK_WIDTH = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH = 3,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_F000}}
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_valid,
  output logic a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0] a_param,
  input  logic [SIZE_WIDTH-1:0] a_size,
  input  logic [SRC_WIDTH-1:0] a_source,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [MASK_WIDTH-1:0] a_mask,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic d_valid,
  input  logic d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0] d_param,
  output logic [SIZE_WIDTH-1:0] d_size,
  output logic [SRC_WIDTH-1:0] d_source,
  output logic [SINK_WIDTH-1:0] d_sink,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic d_error,
  output logic [NUM_SLAVES-1:0] a_valid_out,
  input  logic [NUM_SLAVES-1:0] a_ready_out,
  output logic [NUM_SLAVES*OPCODE_WIDTH-1:0] a_opcode_out,
  output logic [NUM_SLAVES*PARAM_WIDTH-1:0] a_param_out,
  output logic [NUM_SLAVES*SIZE_WIDTH-1:0] a_size_out,
  output logic [NUM_SLAVES*SRC_WIDTH-1:0] a_source_out,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0] a_address_out,
  output logic [NUM_SLAVES*MASK_WIDTH-1:0] a_mask_out,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0] a_data_out,
  input  logic [NUM_SLAVES-1:0] d_valid_in,
  output logic [NUM_SLAVES-1:0] d_ready_in,
  input  logic [NUM_SLAVES*OPCODE_WIDTH-1:0] d_opcode_in,
  input  logic [NUM_SLAVES*PARAM_WIDTH-1:0] d_param_in,
  input  logic [NUM_SLAVES*SIZE_WIDTH-1:0] d_size_in,
  input  logic [NUM_SLAVES*SRC_WIDTH-1:0] d_source_in,
  input  logic [NUM_SLAVES*SINK_WIDTH-1:0] d_sink_in,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] d_data_in,
  input  logic [NUM_SLAVES-1:0] d_error_in
);
  localparam int TW = $clog2(NUM_SLAVES + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [TW-1:0] dest, tgt;
  logic [CW-1:0] out_cnt;
  logic dest_err, err_idle, accept, a_fire, d_fire;
`ifdef TLUL_SOCKET_ERR_RESP_EN
  localparam logic [TW-1:0] ERR = TW'(NUM_SLAVES);
  localparam logic [TW-1:0] DEF = ERR;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;
  logic [0:0] err_state;
  logic [OPCODE_WIDTH-1:0] err_opcode;
  logic [SRC_WIDTH-1:0] err_source;
  logic [SIZE_WIDTH-1:0] err_size;
  assign dest_err = dest == ERR;
  assign err_idle = err_state == IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      err_state <= IDLE;
      err_opcode <= '0;
      err_source <= '0;
      err_size <= '0;
    end else if (err_state == IDLE && a_fire && dest_err) begin
      err_state <= RESP;
      err_opcode <= (a_opcode == OPCODE_WIDTH'(4)) ? OPCODE_WIDTH'(1) : '0;
      err_source <= a_source;
      err_size <= a_size;
    end else if (err_state == RESP && d_ready) err_state <= IDLE;
`else
  localparam logic [TW-1:0] DEF = TW'(NUM_SLAVES - 1);
  assign dest_err = 1'b0;
  assign err_idle = 1'b1;
`endif
  // Scan downward so the lowest-indexed hit is the one that sticks.
  always_comb begin
    dest = DEF;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((a_address & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) dest = TW'(i);
  end
  assign accept = (out_cnt == '0) || (dest == tgt && !dest_err && out_cnt < CW'(MAX_OUTSTANDING));
  always_comb begin
    a_valid_out = '0;
    a_ready = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (reset_n && dest == TW'(i)) begin
        a_valid_out[i] = a_valid & accept;
        a_ready = accept & a_ready_out[i];
      end
    if (reset_n && dest_err) a_ready = accept & err_idle;
  end
  assign a_opcode_out = reset_n ? {NUM_SLAVES{a_opcode}} : '0;
  assign a_param_out = reset_n ? {NUM_SLAVES{a_param}} : '0;
  assign a_size_out = reset_n ? {NUM_SLAVES{a_size}} : '0;
  assign a_source_out = reset_n ? {NUM_SLAVES{a_source}} : '0;
  assign a_address_out = reset_n ? {NUM_SLAVES{a_address}} : '0;
  assign a_mask_out = reset_n ? {NUM_SLAVES{a_mask}} : '0;
  assign a_data_out = reset_n ? {NUM_SLAVES{a_data}} : '0;
  always_comb begin
    d_valid = 1'b0;
    d_opcode = '0;
    d_param = '0;
    d_size = '0;
    d_source = '0;
    d_sink = '0;
    d_data = '0;
    d_error = 1'b0;
    d_ready_in = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (reset_n && tgt == TW'(i)) begin
        d_valid = d_valid_in[i];
        d_opcode = d_opcode_in[i*OPCODE_WIDTH +: OPCODE_WIDTH];
        d_param = d_param_in[i*PARAM_WIDTH +: PARAM_WIDTH];
        d_size = d_size_in[i*SIZE_WIDTH +: SIZE_WIDTH];
        d_source = d_source_in[i*SRC_WIDTH +: SRC_WIDTH];
        d_sink = d_sink_in[i*SINK_WIDTH +: SINK_WIDTH];
        d_data = d_data_in[i*DATA_WIDTH +: DATA_WIDTH];
        d_error = d_error_in[i];
        d_ready_in[i] = d_ready;
      end
`ifdef TLUL_SOCKET_ERR_RESP_EN
    if (reset_n && tgt == ERR) begin
      d_valid = err_state;
      d_opcode = err_opcode;
      d_size = err_size;
      d_source = err_source;
      d_error = err_state;
    end
`endif
  end
  assign a_fire = a_valid & a_ready;
  assign d_fire = d_valid & d_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_cnt <= '0;
      tgt <= '0;
    end else begin
      if (a_fire) tgt <= dest;
      if (a_fire && !d_fire) out_cnt <= out_cnt + 1'b1;
      else if (d_fire && !a_fire) out_cnt <= out_cnt - 1'b1;
    end
endmodule

// File: tb/tb_tlul_socket_1n.sv
// tb_tlul_socket_1n: directed scenarios plus randomized traffic against a queue-based socket model.
// Error-responder checks follow TLUL_SOCKET_ERR_RESP_EN, matching the RTL build.
module tb_tlul_socket_1n;
  localparam int NS = 4, AW = 32, DW = 32, MO = 4;
  localparam logic [NS*AW-1:0] BASE = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
  localparam logic [NS*AW-1:0] MASK = {NS{32'hFFFF_F000}};
`ifdef TLUL_SOCKET_ERR_RESP_EN
  localparam int UNMAPPED = NS;
`else
  localparam int UNMAPPED = NS - 1;
`endif
  logic clk = 0, reset_n;
  logic a_valid, a_ready, d_valid, d_ready, d_error;
  logic [2:0] a_opcode, a_param, a_size, d_opcode, d_param, d_size;
  logic [1:0] a_source, d_source;
  logic [0:0] d_sink;
  logic [31:0] a_address, a_data, d_data;
  logic [3:0] a_mask;
  logic [NS-1:0] a_valid_out, a_ready_out, d_valid_in, d_ready_in, d_error_in, d_sink_in;
  logic [NS*3-1:0] a_opcode_out, a_param_out, a_size_out, d_opcode_in, d_param_in, d_size_in;
  logic [NS*2-1:0] a_source_out, d_source_in;
  logic [NS*AW-1:0] a_address_out;
  logic [NS*4-1:0] a_mask_out;
  logic [NS*DW-1:0] a_data_out, d_data_in;
  logic u2_a_ready, u2_d_valid, u2_d_error;
  logic [2:0] u2_d_opcode, u2_d_param, u2_d_size;
  logic [1:0] u2_d_source;
  logic [0:0] u2_d_sink;
  logic [31:0] u2_d_data;
  logic [NS-1:0] u2_a_valid_out, u2_d_ready_in;
  logic [NS*3-1:0] u2_a_opcode_out, u2_a_param_out, u2_a_size_out;
  logic [NS*2-1:0] u2_a_source_out;
  logic [NS*AW-1:0] u2_a_address_out;
  logic [NS*4-1:0] u2_a_mask_out;
  logic [NS*DW-1:0] u2_a_data_out;
  int vectors = 0, miscompares = 0;
  int m_n, m_last;
  logic [31:0] m_rq[$];
  logic [2:0] m_err_op;
  logic [1:0] m_err_src;

  always #5 clk = ~clk;

  tlul_socket_1n #(.NUM_SLAVES(NS), .MAX_OUTSTANDING(MO), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
    .a_valid_out(a_valid_out), .a_ready_out(a_ready_out), .a_opcode_out(a_opcode_out),
    .a_param_out(a_param_out), .a_size_out(a_size_out), .a_source_out(a_source_out),
    .a_address_out(a_address_out), .a_mask_out(a_mask_out), .a_data_out(a_data_out),
    .d_valid_in(d_valid_in), .d_ready_in(d_ready_in), .d_opcode_in(d_opcode_in), .d_param_in(d_param_in),
    .d_size_in(d_size_in), .d_source_in(d_source_in), .d_sink_in(d_sink_in), .d_data_in(d_data_in),
    .d_error_in(d_error_in));

  // Default map: every slave sits at 0x0, so all of them overlap there.
  tlul_socket_1n u2 (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(u2_a_ready), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(u2_d_valid), .d_ready(d_ready), .d_opcode(u2_d_opcode), .d_param(u2_d_param), .d_size(u2_d_size),
    .d_source(u2_d_source), .d_sink(u2_d_sink), .d_data(u2_d_data), .d_error(u2_d_error),
    .a_valid_out(u2_a_valid_out), .a_ready_out(a_ready_out), .a_opcode_out(u2_a_opcode_out),
    .a_param_out(u2_a_param_out), .a_size_out(u2_a_size_out), .a_source_out(u2_a_source_out),
    .a_address_out(u2_a_address_out), .a_mask_out(u2_a_mask_out), .a_data_out(u2_a_data_out),
    .d_valid_in(d_valid_in), .d_ready_in(u2_d_ready_in), .d_opcode_in(d_opcode_in), .d_param_in(d_param_in),
    .d_size_in(d_size_in), .d_source_in(d_source_in), .d_sink_in(d_sink_in), .d_data_in(d_data_in),
    .d_error_in(d_error_in));

  function automatic int decode(input logic [31:0] addr);
    for (int i = 0; i < NS; i++)
      if ((addr & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) return i;
    return UNMAPPED;
  endfunction

  task automatic idle_inputs;
    a_valid = 0; a_opcode = 0; a_param = 0; a_size = 2; a_source = 0; a_address = 0; a_mask = 4'hF; a_data = 0;
    d_ready = 0; a_ready_out = 4'hF; d_valid_in = 0; d_error_in = 0; d_sink_in = 0;
    d_opcode_in = 0; d_param_in = 0; d_size_in = 0; d_source_in = 0; d_data_in = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    idle_inputs();
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    m_n = 0; m_last = 0; m_rq.delete();
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 0;
    a_valid = 1; a_address = 32'h1004; a_data = $urandom; a_ready_out = 4'hF;
    d_valid_in = 4'hF; d_data_in = {$urandom, $urandom, $urandom, $urandom}; d_ready = 1;
    #1;
    vectors += 8;
    if (a_ready !== 1'b0) begin $display("FAIL reset_a_ready got %b want 0", a_ready); miscompares++; end
    if (a_valid_out !== 4'h0) begin $display("FAIL reset_a_valid_out got %b want 0000", a_valid_out); miscompares++; end
    if (d_valid !== 1'b0) begin $display("FAIL reset_d_valid got %b want 0", d_valid); miscompares++; end
    if (d_ready_in !== 4'h0) begin $display("FAIL reset_d_ready_in got %b want 0000", d_ready_in); miscompares++; end
    if (a_data_out !== '0) begin $display("FAIL reset_a_data_out got %h want 0", a_data_out); miscompares++; end
    if (d_data !== 32'h0) begin $display("FAIL reset_d_data got %h want 0", d_data); miscompares++; end
    if (dut.out_cnt !== '0) begin $display("FAIL reset_out_cnt got %0d want 0", dut.out_cnt); miscompares++; end
    if (dut.tgt !== '0) begin $display("FAIL reset_tgt got %0d want 0", dut.tgt); miscompares++; end
    @(negedge clk);
    idle_inputs();
    reset_n = 1;
  endtask

  task automatic test_overlap;
    @(negedge clk);
    a_valid = 1; a_address = 32'h0; a_ready_out = 4'h0;
    #1;
    vectors += 2;
    if (u2_a_valid_out !== 4'b0001) begin $display("FAIL overlap_route got %b want 0001", u2_a_valid_out); miscompares++; end
    if (a_valid_out !== 4'b0001) begin $display("FAIL slave0_route got %b want 0001", a_valid_out); miscompares++; end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_get_slave1;
    @(negedge clk);
    a_valid = 1; a_opcode = 4; a_address = 32'h1004; a_source = 1; a_data = 32'h1234_5678;
    #1;
    vectors += 4;
    if (a_valid_out !== 4'b0010) begin $display("FAIL get1_valid_out got %b want 0010", a_valid_out); miscompares++; end
    if (a_ready !== 1'b1) begin $display("FAIL get1_a_ready got %b want 1", a_ready); miscompares++; end
    if (a_data_out[2*DW +: DW] !== 32'h1234_5678) begin $display("FAIL get1_bcast_data got %h want 12345678", a_data_out[2*DW +: DW]); miscompares++; end
    if (a_address_out[0 +: AW] !== 32'h1004) begin $display("FAIL get1_bcast_addr got %h want 1004", a_address_out[0 +: AW]); miscompares++; end
    @(negedge clk);
    a_valid = 0; d_valid_in = 4'hF; d_ready = 1;
    d_data_in = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_0000};
    #1;
    vectors += 3;
    if (d_valid !== 1'b1) begin $display("FAIL get1_d_valid got %b want 1", d_valid); miscompares++; end
    if (d_data !== 32'hDEAD_BEEF) begin $display("FAIL get1_d_data got %h want deadbeef", d_data); miscompares++; end
    if (d_ready_in !== 4'b0010) begin $display("FAIL get1_d_ready_in got %b want 0010", d_ready_in); miscompares++; end
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (dut.out_cnt !== '0) begin $display("FAIL get1_drain got %0d want 0", dut.out_cnt); miscompares++; end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a_valid = 1; a_opcode = 0; a_address = 32'h2000 + 32'(i * 4); a_data = $urandom;
      #1;
      vectors++;
      if (a_ready !== (i < MO)) begin $display("FAIL b2b_ready[%0d] got %b want %b", i, a_ready, i < MO); miscompares++; end
    end
    @(negedge clk);
    d_valid_in = 4'b0100; d_ready = 1;
    #1;
    vectors += 2;
    if (a_ready !== 1'b0) begin $display("FAIL b2b_full_with_dfire got %b want 0", a_ready); miscompares++; end
    if (d_valid !== 1'b1) begin $display("FAIL b2b_d_valid got %b want 1", d_valid); miscompares++; end
    @(negedge clk);
    d_valid_in = 0;
    #1;
    vectors++;
    if (a_ready !== 1'b1) begin $display("FAIL b2b_after_dfire got %b want 1", a_ready); miscompares++; end
    @(negedge clk);
    a_valid = 0;
    #1;
    vectors++;
    if (dut.out_cnt !== 3'(MO)) begin $display("FAIL b2b_out_cnt got %0d want %0d", dut.out_cnt, MO); miscompares++; end
    d_valid_in = 4'b0100; d_ready = 1;
    repeat (MO) @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    vectors++;
    if (dut.out_cnt !== '0) begin $display("FAIL b2b_drain got %0d want 0", dut.out_cnt); miscompares++; end
  endtask

  task automatic test_stall_other;
    @(negedge clk);
    a_valid = 1; a_opcode = 0; a_address = 32'h0010;
    #1;
    vectors++;
    if (a_ready !== 1'b1) begin $display("FAIL stall_put0 got %b want 1", a_ready); miscompares++; end
    @(negedge clk);
    a_opcode = 4; a_address = 32'h3000;
    #1;
    vectors += 2;
    if (a_ready !== 1'b0) begin $display("FAIL stall_get3_ready got %b want 0", a_ready); miscompares++; end
    if (a_valid_out !== 4'h0) begin $display("FAIL stall_get3_valid got %b want 0000", a_valid_out); miscompares++; end
    @(negedge clk);
    d_valid_in = 4'b0001; d_ready = 1;
    #1;
    vectors++;
    if (a_ready !== 1'b0) begin $display("FAIL stall_same_cycle got %b want 0", a_ready); miscompares++; end
    @(negedge clk);
    d_valid_in = 0;
    #1;
    vectors += 2;
    if (a_ready !== 1'b1) begin $display("FAIL stall_release got %b want 1", a_ready); miscompares++; end
    if (a_valid_out !== 4'b1000) begin $display("FAIL stall_release_valid got %b want 1000", a_valid_out); miscompares++; end
    @(negedge clk);
    a_valid = 0;
    #1;
    vectors += 2;
    if (dut.tgt !== 3'd3) begin $display("FAIL stall_tgt got %0d want 3", dut.tgt); miscompares++; end
    if (dut.out_cnt !== 3'd1) begin $display("FAIL stall_cnt got %0d want 1", dut.out_cnt); miscompares++; end
    d_valid_in = 4'b1000;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_unmapped;
    @(negedge clk);
    a_valid = 1; a_opcode = 4; a_source = 2; a_size = 2; a_address = 32'h8000_0000;
    d_ready = 0;
`ifdef TLUL_SOCKET_ERR_RESP_EN
    #1;
    vectors += 2;
    if (a_ready !== 1'b1) begin $display("FAIL err_a_ready got %b want 1", a_ready); miscompares++; end
    if (a_valid_out !== 4'h0) begin $display("FAIL err_a_valid_out got %b want 0000", a_valid_out); miscompares++; end
    @(negedge clk);
    a_valid = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors += 5;
      if (d_valid !== 1'b1) begin $display("FAIL err_d_valid[%0d] got %b want 1", k, d_valid); miscompares++; end
      if (d_opcode !== 3'd1) begin $display("FAIL err_d_opcode[%0d] got %0d want 1", k, d_opcode); miscompares++; end
      if (d_source !== 2'd2) begin $display("FAIL err_d_source[%0d] got %0d want 2", k, d_source); miscompares++; end
      if (d_error !== 1'b1) begin $display("FAIL err_d_error[%0d] got %b want 1", k, d_error); miscompares++; end
      if (d_data !== 32'h0) begin $display("FAIL err_d_data[%0d] got %h want 0", k, d_data); miscompares++; end
      @(negedge clk);
    end
    d_ready = 1;
    #1;
    vectors++;
    if (d_size !== 3'd2) begin $display("FAIL err_d_size got %0d want 2", d_size); miscompares++; end
    @(negedge clk);
    d_ready = 0;
    #1;
    vectors += 2;
    if (d_valid !== 1'b0) begin $display("FAIL err_done got %b want 0", d_valid); miscompares++; end
    if (dut.out_cnt !== '0) begin $display("FAIL err_cnt got %0d want 0", dut.out_cnt); miscompares++; end
`else
    #1;
    vectors += 2;
    if (a_valid_out !== 4'b1000) begin $display("FAIL dflt_route got %b want 1000", a_valid_out); miscompares++; end
    if (a_ready !== 1'b1) begin $display("FAIL dflt_a_ready got %b want 1", a_ready); miscompares++; end
    @(negedge clk);
    a_valid = 0; d_valid_in = 4'b1000; d_error_in = 4'b1000; d_ready = 1;
    #1;
    vectors += 2;
    if (d_valid !== 1'b1) begin $display("FAIL dflt_d_valid got %b want 1", d_valid); miscompares++; end
    if (d_error !== 1'b1) begin $display("FAIL dflt_d_error got %b want 1", d_error); miscompares++; end
`endif
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a_valid = 1; a_opcode = 0; a_address = 32'h1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_valid = 0;
    #1;
    vectors++;
    if (dut.out_cnt !== 3'd3) begin $display("FAIL mid_pre_cnt got %0d want 3", dut.out_cnt); miscompares++; end
    a_valid = 1; a_address = 32'h3000; d_valid_in = 4'b0010; d_ready = 1;
    reset_n = 0;
    #1;
    vectors += 5;
    if (a_ready !== 1'b0) begin $display("FAIL mid_a_ready got %b want 0", a_ready); miscompares++; end
    if (a_valid_out !== 4'h0) begin $display("FAIL mid_a_valid_out got %b want 0000", a_valid_out); miscompares++; end
    if (d_valid !== 1'b0) begin $display("FAIL mid_d_valid got %b want 0", d_valid); miscompares++; end
    if (d_ready_in !== 4'h0) begin $display("FAIL mid_d_ready_in got %b want 0000", d_ready_in); miscompares++; end
    if (dut.out_cnt !== '0) begin $display("FAIL mid_cnt got %0d want 0", dut.out_cnt); miscompares++; end
    @(negedge clk);
    reset_n = 1; d_valid_in = 0; d_ready = 0;
    #1;
    vectors += 2;
    if (a_ready !== 1'b1) begin $display("FAIL mid_next_ready got %b want 1", a_ready); miscompares++; end
    if (a_valid_out !== 4'b1000) begin $display("FAIL mid_next_valid got %b want 1000", a_valid_out); miscompares++; end
    @(negedge clk);
    a_valid = 0; d_valid_in = 4'b1000; d_ready = 1;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random;
    logic [2:0] ops[3];
    int dest, sel;
    bit acc, exp_ar, exp_dv, exp_de, a_fire, d_fire;
    logic [3:0] exp_avo;
    logic [31:0] exp_dd;
    logic [2:0] exp_op;
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      sel = $urandom_range(0, 4);
      a_address = (sel < NS) ? (BASE[sel*AW +: AW] | ($urandom & 32'hFFC)) : (32'h8000_0000 | ($urandom & 32'hFFC));
      a_valid = ($urandom_range(0, 3) != 0);
      a_opcode = ops[$urandom_range(0, 2)];
      a_source = 2'($urandom); a_size = 3'($urandom); a_data = $urandom;
      a_ready_out = 4'($urandom);
      d_ready = ($urandom_range(0, 2) != 0);
      d_error_in = 4'($urandom); d_opcode_in = 12'($urandom);
      for (int i = 0; i < NS; i++) begin
        d_valid_in[i] = (i == m_last) ? (m_rq.size() > 0 && $urandom_range(0, 1) == 1) : 1'($urandom);
        d_data_in[i*DW +: DW] = (i == m_last && m_rq.size() > 0) ? m_rq[0] : $urandom;
      end
      #1;
      dest = decode(a_address);
      acc = (m_n == 0) || (dest == m_last && dest != NS && m_n < MO);
      exp_ar = acc && (dest == NS ? 1'b1 : a_ready_out[dest]);
      exp_avo = (dest != NS && a_valid && acc) ? 4'(1 << dest) : 4'h0;
      exp_dv = (m_last == NS) ? (m_n > 0) : d_valid_in[m_last];
      exp_dd = (m_last == NS) ? 32'h0 : d_data_in[m_last*DW +: DW];
      exp_de = (m_last == NS) ? 1'b1 : d_error_in[m_last];
      exp_op = (m_last == NS) ? m_err_op : d_opcode_in[m_last*3 +: 3];
      vectors += 3;
      if (a_ready !== exp_ar) begin $display("FAIL rnd_a_ready c=%0d got %b want %b", c, a_ready, exp_ar); miscompares++; end
      if (a_valid_out !== exp_avo) begin $display("FAIL rnd_a_valid_out c=%0d got %b want %b", c, a_valid_out, exp_avo); miscompares++; end
      if (d_valid !== exp_dv) begin $display("FAIL rnd_d_valid c=%0d got %b want %b", c, d_valid, exp_dv); miscompares++; end
      if (exp_dv) begin
        vectors += 3;
        if (d_data !== exp_dd) begin $display("FAIL rnd_d_data c=%0d got %h want %h", c, d_data, exp_dd); miscompares++; end
        if (d_error !== exp_de) begin $display("FAIL rnd_d_error c=%0d got %b want %b", c, d_error, exp_de); miscompares++; end
        if (d_opcode !== exp_op) begin $display("FAIL rnd_d_opcode c=%0d got %0d want %0d", c, d_opcode, exp_op); miscompares++; end
        if (m_last == NS) begin
          vectors++;
          if (d_source !== m_err_src) begin $display("FAIL rnd_err_source c=%0d got %0d want %0d", c, d_source, m_err_src); miscompares++; end
        end
      end
      a_fire = a_valid && exp_ar;
      d_fire = exp_dv && d_ready;
      if (d_fire) begin
        m_n--;
        if (m_last != NS) void'(m_rq.pop_front());
      end
      if (a_fire) begin
        m_n++;
        m_last = dest;
        if (dest != NS) m_rq.push_back($urandom);
        else begin
          m_err_op = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
          m_err_src = a_source;
        end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset_n = 0;
    test_reset();
    test_overlap();
    test_get_slave1();
    test_back_to_back();
    test_stall_other();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tlul_socket_1n.md
# tlul_socket_1n

Parametrised 1-to-N TL-UL peripheral socket. It sits in the 24 MHz domain between the CDC adapter output and up to NUM_SLAVES peripheral devices. It decodes each Channel A request by address and steers it to one slave. It also tracks outstanding transactions so that D responses return in order, and it answers unmapped addresses with an internal error response.

## Interface
- NUM_SLAVES, 4: number of downstream slaves (1..8)
- ADDR_WIDTH, 32; DATA_WIDTH, 32; MASK_WIDTH, DATA_WIDTH/8: TL-UL field widths
- SIZE_WIDTH, 3; SRC_WIDTH, 2; SINK_WIDTH, 1; OPCODE_WIDTH, 3; PARAM_WIDTH, 3: TL-UL field widths
- MAX_OUTSTANDING, 4: maximum number of in-flight requests (1..15)
- SLAVE_BASE, {NUM_SLAVES{32'h0}}: flat NUM_SLAVES*ADDR_WIDTH vector; slot i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- SLAVE_MASK, {NUM_SLAVES{32'hFFFF_F000}}: flat vector, same layout as SLAVE_BASE

Ports:
- clk  in  1  socket clock (24 MHz domain)
- reset_n  in  1  asynchronous, active-low reset
- a_valid, a_ready  in/out  1  upstream Channel A handshake
- a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data  in  field widths  upstream A payload
- d_valid, d_ready  out/in  1  upstream Channel D handshake
- d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error  out  field widths  upstream D payload
- a_valid_out, a_ready_out  out/in  NUM_SLAVES  per-slave A handshake
- a_opcode_out … a_data_out  out  NUM_SLAVES*field  per-slave A payload (flat vectors)
- d_valid_in, d_ready_in  in/out  NUM_SLAVES  per-slave D handshake
- d_opcode_in … d_error_in  in  NUM_SLAVES*field  per-slave D payload (flat vectors)

## Operation
- Decode: hit_i = ((a_address & MASK_i) == BASE_i). The lowest-indexed hit wins. If no slave hits, the destination is ERR (index NUM_SLAVES).
- State registers:
  - out_cnt, width $clog2(MAX_OUTSTANDING+1)
  - tgt, width $clog2(NUM_SLAVES+1): destination of the in-flight requests
- Accept condition: accept = (out_cnt==0) || (dest==tgt && dest!=ERR && out_cnt<MAX_OUTSTANDING). Both terms use registered out_cnt and tgt.
- A path, combinational:
  - a_valid_out[dest] = a_valid & accept; every other bit is 0.
  - a_ready = accept & a_ready_out[dest] when dest is a slave; a_ready = accept & (err_state==IDLE) when dest is ERR.
  - Payload is broadcast to all slaves unmodified.
- On an A fire, tgt<=dest.
- Counter update:
  - out_cnt increments on an A fire only.
  - out_cnt decrements on a D fire only.
  - It is unchanged when both fire in the same cycle.
- D path:
  - d_* = slave tgt's d_*_in.
  - d_ready_in[tgt] = d_ready; every other bit is 0.
  - d_valid_in from non-target slaves is ignored.
- Error responder state machine, states IDLE and RESP:
  - IDLE→RESP on an A fire to ERR. On that transition the block captures source and size, and latches opcode: AccessAckData (1) for Get (4), otherwise AccessAck (0).
  - RESP drives d_valid=1, d_data=0, d_param=0, d_sink=0, d_error=1, plus the captured fields.
  - RESP→IDLE on d_ready.
- A request to a different destination while requests are outstanding stalls (a_ready=0) until out_cnt returns to 0.

## Timing
- Reset values:
  - a_ready=0, d_valid=0, a_valid_out=0, d_ready_in=0.
  - out_cnt=0, tgt=0, error state machine=IDLE.
  - All payload outputs are 0.
- A→slave latency: 0 cycles (combinational).
- Slave D→upstream latency: 0 cycles.
- Error response: d_valid asserts the cycle after the A fire and holds until d_ready.
- A D fire from out_cnt=1 that coincides with a new request to another slave does not unblock that cycle. The request is accepted the next cycle.
- At out_cnt==MAX_OUTSTANDING, a_ready=0 even if a D fire occurs in the same cycle.
- Reset asserted mid-transaction clears all state immediately. Responses in flight are dropped, and the slaves are reset in the same domain.
- Valid must not depend on ready on any port.

## Configuration
- TLUL_SOCKET_ERR_RESP_EN defined: the internal error responder is present, as described above.
- Not defined: the responder is removed and unmapped requests route to slave NUM_SLAVES-1 (default slave). ERR is never a destination, and d_error is purely passed through from the target slave.

## Test plan
- Get to 0x0000_1004 with BASE1=0x1000 and MASK=0xFFFF_F000: only a_valid_out[1] asserts. Slave 1 returns data 0xDEAD_BEEF, which appears on d_data the same cycle.
- Five back-to-back Puts to slave 2 with MAX_OUTSTANDING=4 and slaves holding D: the fifth stalls with a_ready=0. After one D fire it is accepted the following cycle, and out_cnt reads 4.
- Put to slave 0 outstanding, then Get to slave 3: the Get stalls until slave 0's D fires. It is then accepted, with tgt=3.
- Get to unmapped 0x8000_0000 with source 2 (macro defined): the cycle after the A fire, d_valid=1, opcode=1, source=2, d_error=1, data=0. It holds under d_ready=0 for 3 cycles, then completes.
- Overlapping regions, slaves 0 and 1 both hitting 0x0: routed to slave 0.
- reset_n pulsed low with out_cnt=3: all outputs go to reset values immediately. The next request, to any slave, is accepted with out_cnt=0.
